// File: rtl/memory_stage.sv
// MEM pipeline stage: issues load/store requests on the data-memory port, aligns and
// extends load data, and registers the write-back value into the MEM/WB register.
module memory_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pipe_en,
    input  logic [6:0]   cwMEM,
    input  logic [N-1:0] ALUres,
    input  logic [N-1:0] Bout,
    input  logic [N-1:0] NPC4_IN,
    input  logic [N-1:0] Rdest_in,
    output logic [N-1:0] EXMEMfwd,
    output logic         stall_mem,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [N-1:0] dmem_addr,
    output logic [3:0]   dmem_be,
    output logic [N-1:0] dmem_wdata,
    input  logic         dmem_gnt,
    input  logic         dmem_rvalid,
    input  logic [N-1:0] dmem_rdata,
    output logic [N-1:0] WBdata,
    output logic [4:0]   WBrd,
    output logic         WBwe,
    output logic         misalign
);
    typedef enum logic [1:0] {IDLE, RESP, DONE} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] wbdata_q, wbdata_d;
    logic [4:0]   wbrd_q, wbrd_d;
    logic         wbwe_q, wbwe_d;
    logic         mis_q, mis_d;

    logic         rf_we, mem_rd, mem_wr, uns, link;
    logic [1:0]   size, a;
    logic         is_mem, misal, access;
    logic [N-1:0] rshift, ld_data;
    logic         req, stall, complete, capture;
    logic         unused_ok;

    assign rf_we  = cwMEM[6];
    assign mem_rd = cwMEM[5];
    assign mem_wr = cwMEM[4];
    assign size   = cwMEM[3:2];
    assign uns    = cwMEM[1];
    assign link   = cwMEM[0];
    assign a      = ALUres[1:0];

    assign is_mem = mem_rd | mem_wr;
    assign misal  = is_mem & (((size == 2'b01) & a[0]) | (size[1] & (a != 2'b00)));
    assign access = is_mem & ~misal;

    assign EXMEMfwd  = link ? NPC4_IN : ALUres;
    assign dmem_we   = mem_wr;
    assign dmem_addr = {ALUres[N-1:2], 2'b00};
    assign unused_ok = ^Rdest_in[N-1:5];

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = Bout;
        case (size)
            2'b00: begin
                dmem_be    = 4'b0001 << a;
                dmem_wdata = {(N/8){Bout[7:0]}};
            end
            2'b01: begin
                dmem_be    = 4'b0011 << a;
                dmem_wdata = {(N/16){Bout[15:0]}};
            end
            default: ;
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend to the full word.
    always_comb begin
        rshift  = dmem_rdata >> {a, 3'b000};
        ld_data = dmem_rdata;
        case (size)
            2'b00:   ld_data = uns ? {{(N-8){1'b0}}, rshift[7:0]}
                               : {{(N-8){rshift[7]}}, rshift[7:0]};
            2'b01:   ld_data = uns ? {{(N-16){1'b0}}, rshift[15:0]}
                               : {{(N-16){rshift[15]}}, rshift[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        req      = 1'b0;
        stall    = 1'b0;
        complete = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    req = 1'b1;
                    if (mem_wr && dmem_gnt) begin
                        complete = 1'b1;
                    end else begin
                        stall = 1'b1;
                        if (dmem_gnt) state_d = RESP;
                    end
                end else begin
                    capture = 1'b1;
                end
            end
            RESP: begin
                if (dmem_rvalid) complete = 1'b1;
                else             stall    = 1'b1;
            end
            DONE:    if (pipe_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A finished access parks in DONE while the op is still held, so it is never re-issued.
        if (complete) begin
            capture = 1'b1;
            state_d = pipe_en ? IDLE : DONE;
        end
    end

    // Gated by reset so the request drops immediately, not at the next edge.
    assign dmem_req  = req & ~rst;
    assign stall_mem = stall & ~rst;

    always_comb begin
        wbwe_d   = 1'b0;
        mis_d    = 1'b0;
        wbdata_d = wbdata_q;
        wbrd_d   = wbrd_q;
        if (capture) begin
            wbwe_d   = rf_we & ~misal;
            mis_d    = misal;
            wbdata_d = mem_rd ? ld_data : (link ? NPC4_IN : ALUres);
            wbrd_d   = Rdest_in[4:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wbdata_q <= '0;
            wbrd_q   <= '0;
            wbwe_q   <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wbdata_q <= wbdata_d;
            wbrd_q   <= wbrd_d;
            wbwe_q   <= wbwe_d;
            mis_q    <= mis_d;
        end
    end

    assign WBdata   = wbdata_q;
    assign WBrd     = wbrd_q;
    assign WBwe     = wbwe_q;
    assign misalign = mis_q;
endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: transaction-level model of the MEM stage checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        rst, pipe_en;
    logic [6:0]  cw;
    logic [31:0] alu, bout, npc, rdest;
    logic [31:0] fwd, addr, wdata, rdata, wbdata;
    logic        stall, req, we, gnt, rvalid, wbwe, mis;
    logic [3:0]  be;
    logic [4:0]  wbrd;

    memory_stage #(.N(32)) dut (
        .clk(clk), .rst(rst), .pipe_en(pipe_en), .cwMEM(cw), .ALUres(alu), .Bout(bout),
        .NPC4_IN(npc), .Rdest_in(rdest), .EXMEMfwd(fwd), .stall_mem(stall),
        .dmem_req(req), .dmem_we(we), .dmem_addr(addr), .dmem_be(be), .dmem_wdata(wdata),
        .dmem_gnt(gnt), .dmem_rvalid(rvalid), .dmem_rdata(rdata),
        .WBdata(wbdata), .WBrd(wbrd), .WBwe(wbwe), .misalign(mis)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    // Model of the in-flight access and of the MEM/WB register.
    bit          granted, completed;
    bit          m_we, m_mis;
    logic [31:0] m_data;
    logic [4:0]  m_rd;
    // DUT values seen during the last cycle, for literal checks.
    bit          s_req, s_we, s_stall;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [1:0] a,
                                           input int len, input bit u);
        logic [31:0] s;
        s = w >> (8 * a);
        if (len == 1) return u ? {24'b0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
        if (len == 2) return u ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
        return w;
    endfunction

    task automatic model_reset();
        granted = 0; completed = 0;
        m_we = 0; m_mis = 0; m_data = '0; m_rd = '0;
    endtask

    // One clock: drive memory responses, check combinational outputs, advance the model,
    // then check the MEM/WB register after the edge. Called at posedge+1.
    task automatic cyc(input bit g, input bit rv, input bit hold, input logic [31:0] rdat);
        bit is_st, is_mem, misal, acc, ereq, comp, est, capt;
        int len;
        logic [1:0]  a;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        gnt = g; rvalid = rv; rdata = rdat;
        is_st  = cw[4];
        is_mem = cw[4] | cw[5];
        len    = (cw[3:2] == 2'd0) ? 1 : (cw[3:2] == 2'd1) ? 2 : 4;
        a      = alu[1:0];
        misal  = is_mem && ((int'(a) % len) != 0);
        acc    = is_mem && !misal;
        ereq   = acc && !granted && !completed;
        comp   = (ereq && is_st && g) || (granted && !completed && rv);
        est    = acc && !completed && !comp;
        capt   = !acc || comp;
        pipe_en = !est && !hold;
        #1;
        s_req = req; s_we = we; s_stall = stall; s_addr = addr; s_be = be; s_wdata = wdata;
        chk("req", 32'(req), 32'(ereq));
        chk("stall", 32'(stall), 32'(est));
        chk("fwd", fwd, cw[0] ? npc : alu);
        if (ereq) begin
            ebe = '0; ewd = '0;
            for (int i = 0; i < 4; i++) begin
                if (i >= int'(a) && i < int'(a) + len) ebe[i] = 1'b1;
                ewd[8*i +: 8] = bout[8*(i % len) +: 8];
            end
            chk("we", 32'(we), 32'(is_st));
            chk("addr", addr, alu & 32'hFFFF_FFFC);
            if (is_st) begin
                chk("be", 32'(be), 32'(ebe));
                chk("wdata", wdata, ewd);
            end
        end
        if (capt) begin
            m_we   = cw[6] && !misal;
            m_mis  = misal;
            m_rd   = rdest[4:0];
            m_data = cw[5] ? ld_ext(rdat, a, len, cw[1]) : (cw[0] ? npc : alu);
        end else begin
            m_we = 0; m_mis = 0;
        end
        if (ereq && g && !is_st) granted = 1;
        if (comp) completed = 1;
        if (pipe_en) begin granted = 0; completed = 0; end
        @(posedge clk); #1;
        chk("WBwe", 32'(wbwe), 32'(m_we));
        chk("misalign", 32'(mis), 32'(m_mis));
        chk("WBrd", 32'(wbrd), 32'(m_rd));
        chk("WBdata", wbdata, m_data);
    endtask

    task automatic set_op(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d);
        cw = c; alu = a; bout = b; rdest = {27'b0, d}; npc = 32'h0000_4444;
    endtask

    int op;
    int stalls;

    initial begin
        rst = 1'b1; pipe_en = 1'b1; gnt = 0; rvalid = 0; rdata = '0;
        set_op(7'b1101000, 32'h100, 32'h0, 5'd1);
        model_reset();
        #3;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_WBwe", 32'(wbwe), 32'd0);
        chk("rst_WBdata", wbdata, 32'd0);
        chk("rst_misalign", 32'(mis), 32'd0);
        @(negedge clk);
        set_op(7'b1000000, 32'h1234, 32'h0, 5'd7);
        rst = 1'b0;
        @(posedge clk); #1;

        // ALU op
        cyc(0, 0, 0, 32'h0);
        chk("alu_stall", 32'(s_stall), 32'd0);
        chk("alu_WBwe", 32'(wbwe), 32'd1);
        chk("alu_WBrd", 32'(wbrd), 32'd7);
        chk("alu_WBdata", wbdata, 32'h1234);

        // SB to 0x103, granted at once
        set_op(7'b0010000, 32'h103, 32'hAB, 5'd3);
        cyc(1, 0, 0, 32'h0);
        chk("sb_req", 32'(s_req), 32'd1);
        chk("sb_we", 32'(s_we), 32'd1);
        chk("sb_be", 32'(s_be), 32'b1000);
        chk("sb_wdata", s_wdata, 32'hABABABAB);
        chk("sb_addr", s_addr, 32'h100);
        chk("sb_stall", 32'(s_stall), 32'd0);
        chk("sb_WBwe", 32'(wbwe), 32'd0);

        // LH / LHU at 0x202
        for (int u = 0; u < 2; u++) begin
            set_op(u ? 7'b1100110 : 7'b1100100, 32'h202, 32'h0, 5'd9);
            cyc(1, 0, 0, 32'h0);
            chk("lh_stall0", 32'(s_stall), 32'd1);
            cyc(0, 1, 0, 32'h8001_0000);
            chk("lh_stall1", 32'(s_stall), 32'd0);
            chk("lh_WBdata", wbdata, u ? 32'h0000_8001 : 32'hFFFF_8001);
        end

        // LW 0x300 with grant withheld for three cycles
        set_op(7'b1101000, 32'h300, 32'h0, 5'd12);
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(i == 3, 0, 0, 32'h0);
            stalls += int'(s_stall);
            chk("lw_addr", s_addr, 32'h300);
            chk("lw_WBwe_wait", 32'(wbwe), 32'd0);
        end
        cyc(0, 1, 0, 32'hCAFE_BABE);
        chk("lw_stalls", 32'(stalls + int'(s_stall)), 32'd4);
        chk("lw_WBdata", wbdata, 32'hCAFE_BABE);
        chk("lw_WBwe", 32'(wbwe), 32'd1);
        set_op(7'b0000000, 32'h0, 32'h0, 5'd0);
        cyc(0, 0, 0, 32'h0);
        chk("lw_once", 32'(wbwe), 32'd0);

        // Misaligned LW 0x302
        set_op(7'b1101000, 32'h302, 32'h0, 5'd4);
        cyc(0, 0, 0, 32'h0);
        chk("mis_req", 32'(s_req), 32'd0);
        chk("mis_flag", 32'(mis), 32'd1);
        chk("mis_WBwe", 32'(wbwe), 32'd0);

        // Load completing while the pipe is frozen
        set_op(7'b1101000, 32'h400, 32'h0, 5'd5);
        cyc(1, 0, 0, 32'h0);
        cyc(0, 1, 1, 32'h1111_2222);
        chk("done_WBwe1", 32'(wbwe), 32'd1);
        cyc(0, 0, 1, 32'h0);
        chk("done_req", 32'(s_req), 32'd0);
        chk("done_stall", 32'(s_stall), 32'd0);
        chk("done_WBwe2", 32'(wbwe), 32'd0);
        cyc(0, 0, 0, 32'h0);
        chk("done_WBwe3", 32'(wbwe), 32'd0);

        // Reset while a load response is pending
        set_op(7'b1101000, 32'h500, 32'h0, 5'd6);
        cyc(1, 0, 0, 32'h0);
        rst = 1'b1;
        #1;
        chk("rrst_req", 32'(req), 32'd0);
        chk("rrst_stall", 32'(stall), 32'd0);
        chk("rrst_WBwe", 32'(wbwe), 32'd0);
        chk("rrst_WBdata", wbdata, 32'd0);
        chk("rrst_WBrd", 32'(wbrd), 32'd0);
        model_reset();
        @(negedge clk);
        set_op(7'b0000000, 32'h0, 32'h0, 5'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        cyc(0, 1, 0, 32'hDEAD_BEEF);
        chk("late_rvalid_WBwe", 32'(wbwe), 32'd0);
        chk("late_rvalid_WBdata", wbdata, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit g, rv;
            if (pipe_en) begin
                op = int'($urandom_range(0, 2));
                cw = {1'($urandom_range(0, 1)), 1'(op == 1), 1'(op == 2),
                      2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
                alu   = $urandom;
                bout  = $urandom;
                npc   = $urandom;
                rdest = $urandom;
            end
            g  = 1'($urandom_range(0, 1));
            if (granted && !completed) rv = 1'($urandom_range(0, 1));
            else                       rv = !g && ($urandom_range(0, 7) == 0);
            cyc(g, rv, $urandom_range(0, 3) == 0, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage, directly downstream of the execute stage. It consumes the EX/MEM register outputs (ALU result, store operand, NPC+4, destination, 7-bit MEM control word) and runs load/store accesses on a request/grant/response data-memory port. It sign/zero-extends and aligns load data and registers the write-back value into the MEM/WB register. It stalls the pipeline while an access is outstanding and feeds the EX/MEM forwarding value back to execute.

## Interface
- N, 32, datapath width; byte lanes are defined for N=32 only
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- pipe_en  in  1  global pipeline advance from hazard unit; EX/MEM inputs change only when pipe_en=1
- cwMEM  in  7  [6] rf_we, [5] mem_rd, [4] mem_wr, [3:2] size (00 byte, 01 half, 10 word), [1] unsigned load, [0] link (write back NPC4)
- ALUres  in  N  effective address / ALU result
- Bout  in  N  store data
- NPC4_IN  in  N  return address for link
- Rdest_in  in  N  destination register index, bits [4:0] used
- EXMEMfwd  out  N  combinational: link ? NPC4_IN : ALUres, to execute forward mux
- stall_mem  out  1  combinational stall request to hazard unit
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  N  {ALUres[N-1:2], 2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  N  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid this cycle
- dmem_rdata  in  N  load data word
- WBdata  out  N  MEM/WB write-back value
- WBrd  out  5  MEM/WB destination
- WBwe  out  1  MEM/WB register-file write enable
- misalign  out  1  MEM/WB registered misaligned-access flag

## Operation
- Access op: mem_wr=1 (store; wins if both set) or mem_rd=1 (load), and aligned. Misaligned: half with addr[0]=1, word with addr[1:0]≠0. Misaligned ops issue no request, capture misalign=1, WBwe=0.
- Store: be = byte 0001<<a, half 0011<<a, word 1111 (a = addr[1:0]); wdata = byte {4{B[7:0]}}, half {2{B[15:0]}}, word B.
- Load: byte = rdata[8a+7:8a], half = rdata[8a+15:8a]; sign-extend unless unsigned; word as-is.
- WBdata source: load data if mem_rd, else NPC4_IN if link, else ALUres.
- FSM states:
  - IDLE: with access op, dmem_req=1 and dmem_we/addr/be/wdata driven. gnt with store completes; gnt with load goes to RESP; no gnt keeps requesting.
  - RESP: dmem_req=0; wait for rvalid; rvalid completes.
  - DONE: access already completed, op still held because pipe_en=0; no re-issue; go to IDLE when pipe_en=1.
- On completion: next state is IDLE if pipe_en=1, else DONE.
- stall_mem=1: IDLE with access op and not (store & gnt); or RESP without rvalid. It is 0 in DONE and for non-memory ops.
- MEM/WB register updates every cycle.
  - Capture instruction (WBwe=rf_we & !misalign): non-memory op in IDLE; completion cycle of an access; misaligned op in IDLE.
  - Otherwise load a bubble: WBwe=0, misalign=0, WBdata/WBrd hold.
  - DONE always loads a bubble (no double write).

## Timing
- Reset: state IDLE; WBdata=0, WBrd=0, WBwe=0, misalign=0; dmem_req=0 immediately (async). An rvalid arriving after reset in IDLE is ignored.
- Non-memory op: 0 stall, WB valid the next cycle.
- Store with gnt in first cycle: 0 stall. Each extra no-gnt cycle adds 1 stall.
- Load with gnt in cycle 0 and rvalid in cycle 1: 1 stall cycle; WBdata valid after cycle-1 edge. rvalid is never expected in the same cycle as gnt.
- Request attributes are held stable until gnt; the stall guarantees stable inputs.
- Only one outstanding access.

## Test plan
- ALU op cwMEM=1000000, ALUres=0x1234, Rdest=7 -> next cycle WBwe=1, WBrd=7, WBdata=0x1234; stall_mem never 1.
- SB addr 0x103, Bout=0xAB, gnt same cycle -> req=1, we=1, be=1000, wdata=0xABABABAB, addr=0x100; stall_mem=0; WBwe=0.
- LH signed addr 0x202, gnt cycle 0, rvalid cycle 1 with rdata 0x8001_0000 -> stall_mem 1 then 0; WBdata=0xFFFF8001. Same with LHU -> 0x00008001.
- LW addr 0x300, gnt withheld 3 cycles -> req held with stable addr, stall_mem=1 for 3 cycles plus the RESP cycle; exactly one WB write.
- LW addr 0x302 -> no dmem_req, misalign=1, WBwe=0 the next cycle.
- Load completes with pipe_en=0 for 2 cycles -> state DONE, no second req, WBwe=1 once then 0; rst asserted while in RESP -> dmem_req=0, all outputs 0, late rvalid ignored.
